pacman_steer_ctrl: RTL
======================

Name: pacman_steer_ctrl

Overview:
- Upstream of the Pacman movement block: turns four raw joystick buttons into the registered `direction` that the movement block consumes.
- Synchronises and debounces the buttons, then buffers one requested turn.
- Probes the maze map for the cell adjacent to Pacman in the requested direction, and commits the turn only if that cell is open.
- A blocked request is retried as Pacman moves, and is dropped after a timeout.

Parameters:
- DB_W, 16: debounce counter width.
- DB_CNT, 50000: cycles a synced button must hold its level before the debounced level changes (must be < 2^DB_W).
- INIT_DIR, 3: direction after reset (0 up, 1 left, 2 down, 3 right).
- BORDER_MIN, 1: the target cell coordinate must be > BORDER_MIN.
- BORDER_MAX, 28: the target cell coordinate must be < BORDER_MAX.
- TO_W, 6: timeout counter width.
- REQ_TIMEOUT, 45: `ce` ticks after which a pending request expires (must be < 2^TO_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  game-tick enable (same strobe the movement block uses).
- btn_up, btn_left, btn_down, btn_right  in  1 each  raw active-high buttons, asynchronous to clk.
- cur_x, cur_y  in  5 each  Pacman's current cell.
- map_rd  out  1  map read strobe.
- map_x, map_y  out  5 each  map read address.
- map_wall  in  1  map read data, valid the cycle after map_rd; 1 = wall.
- direction  out  2  committed heading.
- req_pending  out  1  a turn request is buffered.
- turn_ack  out  1  one-cycle pulse when a turn commits.

Behaviour:
- Reset (async, rst_n=0):
  - direction=INIT_DIR; req_pending=0; turn_ack=0; map_rd=0; map_x=map_y=0.
  - FSM=IDLE; sync FFs, debounced levels and all counters = 0.
- Input conditioning:
  - Each button passes through a 2-FF synchroniser, then a per-button counter.
  - The counter resets whenever the synced value equals the debounced level.
  - When the counter reaches DB_CNT-1, the debounced level flips and the counter clears.
- Request capture:
  - A rising edge of a debounced level latches req_dir and sets req_pending=1.
  - The timeout counter clears on capture.
  - Several edges in the same cycle: priority up > left > down > right.
  - A new edge overwrites any pending request, including while a probe is in flight.
- Timeout: while req_pending, each ce increments the counter; at REQ_TIMEOUT the request drops (req_pending=0, no ack).
- FSM states: IDLE, PROBE, WAIT.
  - IDLE, req_pending and req_dir == direction: clear req_pending, pulse turn_ack, no map access.
  - IDLE, req_pending and req_dir != direction:
    - Compute the target cell: up y-1, left x-1, down y+1, right x+1. Arithmetic is 5-bit; a wrapped value is caught by the border test.
    - Border test: target must satisfy > BORDER_MIN and < BORDER_MAX on both axes.
    - Border test fails: stay IDLE, keep the request pending.
    - Skip the probe if (req_dir, cur_x, cur_y) equals the last rejected probe tuple.
    - Otherwise go to PROBE.
  - PROBE (1 cycle):
    - map_rd=1; map_x/map_y = target.
    - Latch probe_dir=req_dir and probe position = (cur_x, cur_y).
    - Go to WAIT.
  - WAIT (1 cycle), sample map_wall:
    - req_dir != probe_dir or req_pending=0 (overwritten or expired): discard the result → IDLE.
    - map_wall=0: direction<=probe_dir, turn_ack=1 for one cycle, req_pending=0, rejected tuple cleared → IDLE.
    - map_wall=1: store the rejected tuple, keep the request pending → IDLE.
  - Re-probing happens only after cur_x/cur_y or req_dir changes.
- Latency from debounced edge to direction update: 3 cycles (capture, PROBE, WAIT; direction registered at the end of WAIT).
- map_rd is high only in PROBE. map_x/map_y hold their last value otherwise.
- Reset mid-probe: everything returns to reset values immediately; a stale map_wall is ignored.

Decomposition:
- Shared package:
  - Direction encoding constants DIR_UP=0, DIR_LEFT=1, DIR_DOWN=2, DIR_RIGHT=3.
  - The FSM state enum.
  - Border constants, also used by the movement block.
- One natural sub-module: btn_debounce, a single-bit 2-FF synchroniser plus debounce counter (parameters DB_W, DB_CNT), instantiated 4 times.

Test Plan:
- Reset → direction=3, req_pending=0, map_rd=0. Assert rst_n low mid-WAIT → same values asynchronously.
- DB_CNT=4. btn_up glitches 2 cycles → no request. Held 10 cycles → req_pending=1. cur=(5,5) → map_rd with map=(5,4); map_wall=0 → direction=0 and turn_ack pulses.
- cur=(5,5), press left, map_wall=1 → direction unchanged, req_pending=1, no re-probe while cur stays (5,5). cur becomes (6,5) → probe at (5,5); wall=0 → direction=1.
- cur=(2,2), press up → target y=1 fails the border test → no map_rd. After REQ_TIMEOUT ce pulses → req_pending=0, no turn_ack.
- Press down, then press left during WAIT → down's result is discarded and a fresh probe runs for left. Press right while direction=3 → turn_ack with no map_rd.
- Buttons up and right rise in the same cycle → req_dir=0 (up wins).

Source files
------------

// File: rtl/pacman_steer_ctrl_pkg.sv
// Shared definitions for Pacman steering: direction encoding, FSM states,
// maze border limits and the neighbour-cell helper.
package pacman_steer_ctrl_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int MAZE_BORDER_MIN = 1;
  localparam int MAZE_BORDER_MAX = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_WAIT
  } steer_st_e;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } cell_t;

  // 5-bit wrap is intentional: an underflow lands at 31 and fails the border test.
  function automatic cell_t step_cell(input logic [1:0] dir,
                                      input logic [4:0] x,
                                      input logic [4:0] y);
    cell_t c;
    c.x = x;
    c.y = y;
    unique case (dir)
      DIR_UP:    c.y = y - 5'd1;
      DIR_LEFT:  c.x = x - 5'd1;
      DIR_DOWN:  c.y = y + 5'd1;
      DIR_RIGHT: c.x = x + 5'd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pacman_steer_ctrl_btn_debounce.sv
// One raw button: 2-FF synchroniser, hold-time debounce, rising-edge pulse
// asserted in the cycle the debounced level is about to go high.
module pacman_steer_ctrl_btn_debounce #(
  parameter int DB_W   = 16,
  parameter int DB_CNT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CNT - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_o = level_d & ~level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pacman_steer_ctrl.sv
// Joystick-to-heading controller: debounces buttons, buffers one turn request
// and commits it only after the maze map reports the adjacent cell open.
module pacman_steer_ctrl
  import pacman_steer_ctrl_pkg::*;
#(
  parameter int DB_W        = 16,
  parameter int DB_CNT      = 50000,
  parameter int INIT_DIR    = 3,
  parameter int BORDER_MIN  = MAZE_BORDER_MIN,
  parameter int BORDER_MAX  = MAZE_BORDER_MAX,
  parameter int TO_W        = 6,
  parameter int REQ_TIMEOUT = 45
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       btn_up,
  input  logic       btn_left,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic [4:0] cur_x,
  input  logic [4:0] cur_y,
  output logic       map_rd,
  output logic [4:0] map_x,
  output logic [4:0] map_y,
  input  logic       map_wall,
  output logic [1:0] direction,
  output logic       req_pending,
  output logic       turn_ack
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(REQ_TIMEOUT - 1);

  logic [3:0] btn_raw, rise;
  assign btn_raw = {btn_right, btn_down, btn_left, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    pacman_steer_ctrl_btn_debounce #(
      .DB_W  (DB_W),
      .DB_CNT(DB_CNT)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_raw[i]),
      .rise_o(rise[i])
    );
  end

  steer_st_e       state_q, state_d;
  logic [1:0]      dir_q, dir_d, req_dir_q, req_dir_d, probe_dir_q, probe_dir_d;
  logic            pend_q, pend_d, ack_q, ack_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [4:0]      map_x_q, map_x_d, map_y_q, map_y_d;
  logic [4:0]      probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic            rej_vld_q, rej_vld_d;
  logic [1:0]      rej_dir_q, rej_dir_d;
  logic [4:0]      rej_x_q, rej_x_d, rej_y_q, rej_y_d;

  logic [1:0] new_dir;
  cell_t      tgt;
  logic       in_border, rej_hit;

  // Later assignments win, giving up > left > down > right.
  always_comb begin
    new_dir = DIR_RIGHT;
    if (rise[2]) new_dir = DIR_DOWN;
    if (rise[1]) new_dir = DIR_LEFT;
    if (rise[0]) new_dir = DIR_UP;
  end

  assign tgt       = step_cell(req_dir_q, cur_x, cur_y);
  assign in_border = (tgt.x > 5'(BORDER_MIN)) && (tgt.x < 5'(BORDER_MAX)) &&
                     (tgt.y > 5'(BORDER_MIN)) && (tgt.y < 5'(BORDER_MAX));
  assign rej_hit   = rej_vld_q && (rej_dir_q == req_dir_q) &&
                     (rej_x_q == cur_x) && (rej_y_q == cur_y);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    req_dir_d   = req_dir_q;
    probe_dir_d = probe_dir_q;
    pend_d      = pend_q;
    ack_d       = 1'b0;
    to_d        = to_q;
    map_x_d     = map_x_q;
    map_y_d     = map_y_q;
    probe_x_d   = probe_x_q;
    probe_y_d   = probe_y_q;
    rej_vld_d   = rej_vld_q;
    rej_dir_d   = rej_dir_q;
    rej_x_d     = rej_x_q;
    rej_y_d     = rej_y_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          if (req_dir_q == dir_q) begin
            pend_d = 1'b0;
            ack_d  = 1'b1;
          end else if (in_border && !rej_hit) begin
            // Probe tuple is captured with the address so both describe the same request.
            state_d     = ST_PROBE;
            map_x_d     = tgt.x;
            map_y_d     = tgt.y;
            probe_dir_d = req_dir_q;
            probe_x_d   = cur_x;
            probe_y_d   = cur_y;
          end
        end
      end
      ST_PROBE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (pend_q && (req_dir_q == probe_dir_q)) begin
          if (!map_wall) begin
            dir_d     = probe_dir_q;
            ack_d     = 1'b1;
            pend_d    = 1'b0;
            rej_vld_d = 1'b0;
          end else begin
            rej_vld_d = 1'b1;
            rej_dir_d = probe_dir_q;
            rej_x_d   = probe_x_q;
            rej_y_d   = probe_y_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pend_q && ce) begin
      if (to_q == TO_LAST) begin
        pend_d = 1'b0;
        to_d   = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    // A fresh press always overrides whatever the request was doing.
    if (|rise) begin
      req_dir_d = new_dir;
      pend_d    = 1'b1;
      to_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= 2'(INIT_DIR);
      req_dir_q   <= '0;
      probe_dir_q <= '0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      to_q        <= '0;
      map_x_q     <= '0;
      map_y_q     <= '0;
      probe_x_q   <= '0;
      probe_y_q   <= '0;
      rej_vld_q   <= 1'b0;
      rej_dir_q   <= '0;
      rej_x_q     <= '0;
      rej_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      req_dir_q   <= req_dir_d;
      probe_dir_q <= probe_dir_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
      to_q        <= to_d;
      map_x_q     <= map_x_d;
      map_y_q     <= map_y_d;
      probe_x_q   <= probe_x_d;
      probe_y_q   <= probe_y_d;
      rej_vld_q   <= rej_vld_d;
      rej_dir_q   <= rej_dir_d;
      rej_x_q     <= rej_x_d;
      rej_y_q     <= rej_y_d;
    end
  end

  assign map_rd      = (state_q == ST_PROBE);
  assign map_x       = map_x_q;
  assign map_y       = map_y_q;
  assign direction   = dir_q;
  assign req_pending = pend_q;
  assign turn_ack    = ack_q;

endmodule
